// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler: two byte requesters share one 8N1/8N2 serial line.
// Bit timing is driven entirely by the external single-cycle baud tick.
module uart_tx_sched #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              tx,
    output logic              busy,
    output logic              grant_id
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_q;
    logic              tx_q;
    logic              busy_q;
    logic              grant_q;
    logic              last_grant_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              stop_cnt_q;
    logic [DATA_W-1:0] shift_q;

    logic winner_d;
    logic accept_d;

    // On a tie the requester that did not own the previous frame wins.
    always_comb begin
        winner_d = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        accept_d = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
    end

    assign req0_ready = accept_d && !winner_d;
    assign req1_ready = accept_d && winner_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            shift_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A baud tick coinciding with acceptance is deliberately ignored.
                    if (accept_d) begin
                        shift_q      <= winner_d ? req1_data : req0_data;
                        grant_q      <= winner_d;
                        last_grant_q <= winner_d;
                        busy_q       <= 1'b1;
                        state_q      <= SYNC;
                    end
                end
                SYNC: begin
                    if (baud) begin
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud) begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (baud) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            tx_q       <= 1'b1;
                            stop_cnt_q <= 1'b0;
                            state_q    <= STOP;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (baud) begin
                        if (stop_cnt_q == LAST_STOP) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule
